axi_master_read_arbiter: RTL and testbench

- Shares the user-side read channels (AR and R) of one AXI master interface among NUM_PORTS requesters.
- Uses round-robin arbitration with one outstanding burst at a time; a grant is held from address acceptance until the last read beat is accepted.
- Sits between the CoRAM memory-channel read engines and the AXI master interface instance; it also checks burst length against rlast.

---
 rtl/axi_master_read_arbiter.sv | 125 ++++++++++++
 tb/tb_axi_master_read_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_read_arbiter.sv
// rtl/axi_master_read_arbiter.sv - round-robin sharing of one AXI master read channel
module axi_master_read_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_PORTS*8-1:0]          req_arlen,
    input  logic [NUM_PORTS-1:0]            req_arvalid,
    output logic [NUM_PORTS-1:0]            req_arready,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    output logic                            req_rlast,
    output logic [NUM_PORTS-1:0]            req_rvalid,
    input  logic [NUM_PORTS-1:0]            req_rready,
    output logic [ADDR_WIDTH-1:0]           araddr,
    output logic [7:0]                      arlen,
    output logic                            arvalid,
    input  logic                            arready,
    input  logic [DATA_WIDTH-1:0]           rdata,
    input  logic                            rlast,
    input  logic                            rvalid,
    output logic                            rready,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            len_error
);
    localparam int PW = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                 state_q;
    logic [PW-1:0]          rr_ptr_q, gidx_q, win, rr_ptr_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]  araddr_q, sel_addr;
    logic [7:0]             arlen_q, sel_len, beat_cnt_q;
    logic                   arvalid_q, len_error_q, found, r_fire;

    // Scan from rr_ptr upward with wrap; first pending requester wins.
    always_comb begin
        logic [PW-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = rr_ptr_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && req_arvalid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = (idx == PW'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        grant_d  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (win == PW'(i)) begin
                sel_addr   = req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len    = req_arlen[i*8 +: 8];
                grant_d[i] = 1'b1;
            end
        end
        rr_ptr_d = (gidx_q == PW'(NUM_PORTS - 1)) ? '0 : gidx_q + 1'b1;
    end

    always_comb begin
        req_arready = '0;
        req_rvalid  = '0;
        if (state_q == IDLE && found) req_arready[win] = 1'b1;
        if (state_q == DATA) req_rvalid[gidx_q] = rvalid;
    end

    assign rready    = (state_q == DATA) && req_rready[gidx_q];
    assign r_fire    = rvalid && rready;
    assign req_rdata = rdata;
    assign req_rlast = rlast;
    assign araddr    = araddr_q;
    assign arlen     = arlen_q;
    assign arvalid   = arvalid_q;
    assign grant     = grant_q;
    assign len_error = len_error_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            beat_cnt_q  <= '0;
            len_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    araddr_q   <= sel_addr;
                    arlen_q    <= sel_len;
                    gidx_q     <= win;
                    grant_q    <= grant_d;
                    beat_cnt_q <= '0;
                    arvalid_q  <= 1'b1;
                    state_q    <= ADDR;
                end
                ADDR: if (arready) begin
                    arvalid_q <= 1'b0;
                    state_q   <= DATA;
                end
                DATA: if (r_fire) begin
                    beat_cnt_q <= beat_cnt_q + 8'd1;
                    // rlast must coincide exactly with the beat numbered arlen
                    if (rlast != (beat_cnt_q == arlen_q)) len_error_q <= 1'b1;
                    if (rlast) begin
                        grant_q  <= '0;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_master_read_arbiter.sv
// tb/tb_axi_master_read_arbiter.sv - directed table plus random bursts against a transaction model
module tb_axi_master_read_arbiter;
    localparam int N = 4;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [N*32-1:0] req_araddr;
    logic [N*8-1:0]  req_arlen;
    logic [N-1:0]  req_arvalid, req_arready, req_rvalid, req_rready, grant;
    logic [31:0]   req_rdata, araddr, rdata;
    logic          req_rlast, arvalid, arready, rlast, rvalid, rready, len_error;
    logic [7:0]    arlen;

    axi_master_read_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arvalid(req_arvalid),
        .req_arready(req_arready), .req_rdata(req_rdata), .req_rlast(req_rlast),
        .req_rvalid(req_rvalid), .req_rready(req_rready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .grant(grant), .len_error(len_error)
    );

    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] port_addr [N];
    logic [7:0]  port_len  [N];
    logic [N-1:0] pend;
    int  m_rr;
    bit  m_err;

    typedef struct {
        bit          rst;
        logic [3:0]  new_mask;
        logic [31:0] addr;
        logic [7:0]  len;
        int          nb;
        int          ar_wait;
        int          mode;
        logic [3:0]  hold;
        int          exp_w;
        bit          exp_err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_araddr[i*32 +: 32] = port_addr[i];
            req_arlen[i*8 +: 8]    = port_len[i];
        end
        req_arvalid = pend;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        pend = '0;
        arready = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        drive_reqs();
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_len_error", len_error, 0);
        chk("rst_rready", rready, 0);
        chk("rst_arready", req_arready, 0);
        ARESET = 1'b0;
        m_rr = 0;
        m_err = 1'b0;
    endtask

    // New ports get addr + port*0x10000 and the given length; already-pending ones keep theirs.
    task automatic add_req(input logic [N-1:0] mask, input logic [31:0] addr, input logic [7:0] len);
        for (int i = 0; i < N; i++) begin
            if (mask[i] && !pend[i]) begin
                port_addr[i] = addr + 32'(i) * 32'h0001_0000;
                port_len[i]  = len;
            end
        end
        pend = pend | mask;
    endtask

    function automatic int model_winner();
        for (int k = 0; k < N; k++)
            if (pend[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    // Starts and ends on a negedge with the DUT idle.
    task automatic run_burst(input int w, input int nb, input int ar_wait, input int mode,
                             input logic [N-1:0] hold, input bit exp_err);
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
        logic [N-1:0] ow;
        int b, cyc;
        ow = N'(1) << w;
        drive_reqs();
        #1;
        chk("arb_arready", req_arready, ow);
        chk("idle_grant", grant, 0);
        chk("idle_arvalid", arvalid, 0);
        exp_addr = port_addr[w];
        exp_len  = port_len[w];
        tick();
        if (!hold[w]) pend[w] = 1'b0;
        port_addr[w] = $urandom;
        drive_reqs();
        rvalid = 1'b1;
        req_rready = '1;
        for (int c = 0; c <= ar_wait; c++) begin
            arready = (c == ar_wait);
            #1;
            chk("addr_arvalid", arvalid, 1);
            chk("addr_araddr", araddr, exp_addr);
            chk("addr_arlen", arlen, exp_len);
            chk("addr_grant", grant, ow);
            chk("addr_arready", req_arready, 0);
            chk("addr_rready", rready, 0);
            chk("addr_rvalid", req_rvalid, 0);
            tick();
        end
        arready = 1'b0;
        rvalid = 1'b0;
        chk("data_arvalid", arvalid, 0);
        b = 0;
        cyc = 0;
        while (b < nb && cyc < 200) begin
            rvalid = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
            rdata = $urandom;
            rlast = (b == nb - 1);
            req_rready = N'($urandom);
            req_rready[w] = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : $urandom_range(1);
            #1;
            chk("data_rready", rready, req_rready[w]);
            chk("data_rvalid", req_rvalid, rvalid ? ow : '0);
            chk("data_rdata", req_rdata, rdata);
            chk("data_rlast", req_rlast, rlast);
            chk("data_grant", grant, ow);
            if (rvalid && req_rready[w]) b++;
            tick();
            cyc++;
        end
        if (b < nb) chk("beat_budget", b, nb);
        rvalid = 1'b0;
        rlast = 1'b0;
        chk("end_grant", grant, 0);
        chk("end_len_error", len_error, exp_err);
        chk("end_rready", rready, 0);
        m_rr = (w + 1) % N;
        m_err = exp_err;
    endtask

    initial begin
        ARESET = 1'b1;
        pend = '0;
        arready = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        rdata = '0;
        req_rready = '0;
        for (int i = 0; i < N; i++) begin
            port_addr[i] = '0;
            port_len[i] = '0;
        end
        drive_reqs();

        //         rst  new      addr          len  nb ar md hold     w err
        tbl[0]  = '{1'b1, 4'b0100, 32'h0000_1000, 8'd3, 4, 0, 0, 4'b0000, 2, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, 32'h0000_2000, 8'd1, 2, 0, 0, 4'b0000, 0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0000, 32'h0,         8'd0, 2, 0, 0, 4'b0000, 1, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 32'h0,         8'd0, 2, 1, 0, 4'b0000, 2, 1'b0};
        tbl[4]  = '{1'b0, 4'b0000, 32'h0,         8'd0, 2, 0, 0, 4'b0000, 3, 1'b0};
        tbl[5]  = '{1'b0, 4'b0010, 32'h0000_3000, 8'd7, 8, 5, 1, 4'b0000, 1, 1'b0};
        tbl[6]  = '{1'b0, 4'b0001, 32'h0000_4000, 8'd3, 2, 0, 0, 4'b0000, 0, 1'b1};
        tbl[7]  = '{1'b0, 4'b1000, 32'h0000_5000, 8'd0, 1, 0, 0, 4'b0000, 3, 1'b1};
        tbl[8]  = '{1'b1, 4'b0100, 32'h0000_6000, 8'd2, 3, 0, 1, 4'b0000, 2, 1'b0};
        tbl[9]  = '{1'b0, 4'b0011, 32'h0000_7000, 8'd1, 2, 0, 0, 4'b0001, 0, 1'b0};
        tbl[10] = '{1'b0, 4'b0000, 32'h0,         8'd0, 2, 0, 0, 4'b0001, 1, 1'b0};
        tbl[11] = '{1'b0, 4'b0000, 32'h0,         8'd0, 2, 0, 0, 4'b0000, 0, 1'b0};

        tick();
        for (int t = 0; t < 12; t++) begin
            if (tbl[t].rst) do_reset();
            add_req(tbl[t].new_mask, tbl[t].addr, tbl[t].len);
            run_burst(tbl[t].exp_w, tbl[t].nb, tbl[t].ar_wait, tbl[t].mode, tbl[t].hold, tbl[t].exp_err);
        end

        // Reset during DATA after one beat of an 8-beat burst.
        do_reset();
        add_req(4'b0010, 32'h0000_8000, 8'd7);
        drive_reqs();
        #1;
        chk("mid_arready", req_arready, 4'b0010);
        tick();
        pend = '0;
        drive_reqs();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1;
        rlast = 1'b0;
        req_rready = '1;
        #1;
        chk("mid_rready", rready, 1);
        tick();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        #1;
        chk("mid_grant", grant, 0);
        chk("mid_rready_after", rready, 0);
        chk("mid_arvalid", arvalid, 0);
        chk("mid_rvalid", req_rvalid, 0);
        rvalid = 1'b0;
        m_rr = 0;
        m_err = 1'b0;
        add_req(4'b1000, 32'h0000_9000, 8'd2);
        run_burst(3, 3, 1, 0, '0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            int w, nb;
            bit e;
            add_req(N'($urandom), $urandom, 8'($urandom_range(7)));
            if (pend == '0) add_req(N'(1) << $urandom_range(N - 1), $urandom, 8'($urandom_range(7)));
            w = model_winner();
            nb = ($urandom_range(4) == 0) ? $urandom_range(1, 8) : int'(port_len[w]) + 1;
            e = m_err || (nb != int'(port_len[w]) + 1);
            run_burst(w, nb, $urandom_range(3), $urandom_range(2), '0, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
